// File: rtl/clock_sched_pkg.sv
// Shared types and defaults for the clock-enable scheduler: FSM states,
// command opcodes and the reset divisor table.
package clock_sched_pkg;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;

    // Channel 0 in the low slot: 50 MHz / {2,10,25} -> 25/5/2 MHz enables.
    localparam logic [NUM_CH-1:0][DIV_W-1:0] DIV_DEFAULT = {8'd25, 8'd10, 8'd2};

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_SYNC  = 2'b00,
        OP_RUN   = 2'b01,
        OP_PAUSE = 2'b10,
        OP_STEP  = 2'b11
    } cmd_op_e;

endpackage

// File: rtl/ce_divider_channel.sv
// One clock-enable channel: a 0..div-1 counter whose terminal count is the
// strobe, with a divisor that reloads from the shared shadow slot.
module ce_divider_channel #(
    parameter int               DIV_W     = 8,
    parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(1)
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             en,
    input  logic             stopped,
    input  logic             sync_clr,
    input  logic             shadow_hit,
    input  logic [DIV_W-1:0] shadow_div,
    output logic             ce,
    output logic             applied
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             wrap;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        wrap    = en && (cnt_q == div_q - DIV_W'(1));
        ce      = wrap;
        applied = shadow_hit && (stopped || wrap);
        cnt_d   = cnt_q;
        div_d   = div_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
        end
        if (sync_clr) begin
            cnt_d = '0;
        end
        // A reload always restarts the phase, so it also wins over SYNC.
        if (applied) begin
            div_d = shadow_div;
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= DIV_RESET;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Run/pause/step scheduler for NUM_CH divided clock enables, with a single
// shadow slot that retimes divisor writes onto each channel's wrap.
module clock_enable_scheduler
    import clock_sched_pkg::*;
#(
    parameter int                              NUM_CH      = clock_sched_pkg::NUM_CH,
    parameter int                              DIV_W       = clock_sched_pkg::DIV_W,
    parameter logic [NUM_CH-1:0][DIV_W-1:0]    DIV_DEFAULT = clock_sched_pkg::DIV_DEFAULT
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] ce,
    output logic              running,
    output logic              cfg_err
);

    state_e           state_q, state_d;
    logic             advance, stopped, cmd_fire, sync_clr;
    logic             cfg_fire, cfg_bad;
    logic             shadow_valid_q, shadow_valid_d;
    logic [1:0]       shadow_ch_q, shadow_ch_d;
    logic [DIV_W-1:0] shadow_div_q, shadow_div_d;
    logic             cfg_err_q, cfg_err_d;
    logic [NUM_CH-1:0] applied;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOPPED: begin
                if (cmd_fire && cmd_op == OP_RUN) begin
                    state_d = ST_RUNNING;
                end else if (cmd_fire && cmd_op == OP_STEP) begin
                    state_d = ST_STEPPING;
                end
            end
            ST_RUNNING: begin
                if (cmd_fire && cmd_op == OP_PAUSE) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_STEPPING: state_d = ST_STOPPED;
            default:     state_d = ST_STOPPED;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q != ST_STEPPING);
        running   = (state_q == ST_RUNNING);
        advance   = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
        stopped   = (state_q == ST_STOPPED);
    end

    assign cmd_fire = cmd_valid && cmd_ready;
    assign sync_clr = cmd_fire && (cmd_op == OP_SYNC);

    // Bad writes are still accepted so a stuck producer cannot wedge the port.
    assign cfg_ready = !shadow_valid_q;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_bad   = (cfg_div == '0) || (int'(cfg_ch) >= NUM_CH);
    assign cfg_err   = cfg_err_q;

    always_comb begin
        shadow_valid_d = shadow_valid_q;
        shadow_ch_d    = shadow_ch_q;
        shadow_div_d   = shadow_div_q;
        cfg_err_d      = 1'b0;
        if (|applied) begin
            shadow_valid_d = 1'b0;
        end
        if (cfg_fire) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                shadow_valid_d = 1'b1;
                shadow_ch_d    = cfg_ch;
                shadow_div_d   = cfg_div;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            shadow_valid_q <= 1'b0;
            shadow_ch_q    <= '0;
            shadow_div_q   <= '0;
            cfg_err_q      <= 1'b0;
        end else begin
            shadow_valid_q <= shadow_valid_d;
            shadow_ch_q    <= shadow_ch_d;
            shadow_div_q   <= shadow_div_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ce_divider_channel #(
            .DIV_W     (DIV_W),
            .DIV_RESET (DIV_DEFAULT[i])
        ) u_ch (
            .clk_50     (clk_50),
            .rst        (rst),
            .en         (advance),
            .stopped    (stopped),
            .sync_clr   (sync_clr),
            .shadow_hit (shadow_valid_q && (int'(shadow_ch_q) == i)),
            .shadow_div (shadow_div_q),
            .ce         (ce[i]),
            .applied    (applied[i])
        );
    end

endmodule
